// File: rtl/counter_ctrl_pkg.sv
// Shared types and default widths for the counter reload sequencer.
package counter_ctrl_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int PRESC_W_DEF  = 8;
  localparam int PERIOD_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..cmp_i, then wraps; term_o flags the last cycle.
module tick_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] cmp_i,
  output logic               term_o
);

  logic [PRESC_W-1:0] cnt_q;

  assign term_o = (cnt_q == cmp_i);

  // Hold at zero while cleared, wrap to zero on terminal, else advance.
  always_ff @(posedge clk) begin
    if (reset || clr_i) cnt_q <= '0;
    else if (term_o)    cnt_q <= '0;
    else                cnt_q <= cnt_q + PRESC_W'(1);
  end

endmodule

// File: rtl/counter_reload_ctrl.sv
// Sequencer driving a parallel-load up-counter through periodic or one-shot
// start..end sequences, with a prescaled advance rate and a tick per sequence.
module counter_reload_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESC_W  = PRESC_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [WIDTH-1:0]    cfg_start,
  input  logic [WIDTH-1:0]    cfg_end,
  input  logic [PRESC_W-1:0]  cfg_presc,
  input  logic                cfg_oneshot,
  input  logic                start,
  input  logic                stop,
  input  logic [WIDTH-1:0]    cnt_q,
  output logic [WIDTH-1:0]    cnt_data,
  output logic                cnt_load,
  output logic                cnt_enable,
  output logic                tick,
  output logic                done,
  output logic                busy,
  output logic [PERIOD_W-1:0] periods
);

  ctrl_state_t         state_q;
  logic [WIDTH-1:0]    start_q;
  logic [WIDTH-1:0]    end_q;
  logic [PRESC_W-1:0]  presc_q;
  logic                oneshot_q;
  logic [PERIOD_W-1:0] periods_q;

  logic presc_term;
  logic step;
  logic at_end;

  tick_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (state_q != RUN),
    .cmp_i  (presc_q),
    .term_o (presc_term)
  );

  // A prescaler terminal in RUN is an advance point unless stop overrides it.
  assign step       = (state_q == RUN) && presc_term && !stop;
  assign at_end     = (cnt_q == end_q);
  assign tick       = step && at_end;
  assign cnt_enable = step && !at_end;
  assign done       = tick && oneshot_q;
  assign cnt_load   = ((state_q == LOAD) && !stop) || (tick && !oneshot_q);
  assign cnt_data   = start_q;
  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign periods    = periods_q;

  // Shadow configuration, writable only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q   <= '0;
      end_q     <= '1;
      presc_q   <= '0;
      oneshot_q <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      start_q   <= cfg_start;
      end_q     <= cfg_end;
      presc_q   <= cfg_presc;
      oneshot_q <= cfg_oneshot;
    end
  end

  // Sequencing FSM and saturating count of completed sequences.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      periods_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= LOAD;
          periods_q <= '0;
        end
        LOAD: state_q <= stop ? IDLE : RUN;
        RUN: begin
          if (tick && (periods_q != '1)) periods_q <= periods_q + PERIOD_W'(1);
          if (stop || done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_reload_ctrl.sv
// Bench for counter_reload_ctrl: closed loop with a behavioural counter,
// outputs compared each cycle against a sequence-age arithmetic model.
module tb_counter_reload_ctrl;
  import counter_ctrl_pkg::*;

  localparam int W  = WIDTH_DEF;
  localparam int PW = PRESC_W_DEF;
  localparam int QW = PERIOD_W_DEF;

  logic          clk = 1'b0;
  logic          reset, cfg_valid, cfg_ready, cfg_oneshot, start, stop;
  logic          cnt_load, cnt_enable, tick, done, busy;
  logic [W-1:0]  cfg_start, cfg_end, cnt_q, cnt_data;
  logic [PW-1:0] cfg_presc;
  logic [QW-1:0] periods;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Downstream counter
  always_ff @(posedge clk) begin
    if (reset)           cnt_q <= '0;
    else if (cnt_load)   cnt_q <= cnt_data;
    else if (cnt_enable) cnt_q <= cnt_q + 1'b1;
  end

  counter_reload_ctrl #(.WIDTH(W), .PRESC_W(PW), .PERIOD_W(QW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_presc(cfg_presc),
    .cfg_oneshot(cfg_oneshot), .start(start), .stop(stop), .cnt_q(cnt_q),
    .cnt_data(cnt_data), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .tick(tick), .done(done), .busy(busy), .periods(periods)
  );

  // Model: a sequence is "active" from its load cycle (age 0); at age a>=1
  // the offset into the current period is (a-1) mod len.
  bit m_act = 0;
  int m_age = 0;
  int m_per = 0;
  int m_start = 0, m_end = 255, m_presc = 0;
  bit m_one = 0;
  int m_cnt = 0;
  bit e_tick;

  function automatic int m_len();
    return (((m_end - m_start) & 255) + 1) * (m_presc + 1);
  endfunction

  function automatic bit m_at_end();
    return m_act && (m_age >= 1) && (((m_age - 1) % m_len()) == m_len() - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit eload, een, edone;
    int o;
    bit last, adv;
    eload = 0; een = 0; edone = 0; e_tick = 0;
    if (m_act && m_age == 0) begin
      eload = !stop;
    end else if (m_act) begin
      o      = (m_age - 1) % m_len();
      last   = (o == m_len() - 1);
      adv    = (((o + 1) % (m_presc + 1)) == 0);
      e_tick = last && !stop;
      een    = adv && !last && !stop;
      eload  = e_tick && !m_one;
      edone  = e_tick && m_one;
      m_cnt  = (m_start + o / (m_presc + 1)) & 255;
    end
    chk("cfg_ready",  32'(cfg_ready),  32'(!m_act));
    chk("busy",       32'(busy),       32'(m_act));
    chk("cnt_load",   32'(cnt_load),   32'(eload));
    chk("cnt_enable", 32'(cnt_enable), 32'(een));
    chk("tick",       32'(tick),       32'(e_tick));
    chk("done",       32'(done),       32'(edone));
    chk("cnt_data",   32'(cnt_data),   32'(m_start));
    chk("periods",    32'(periods),    32'(m_per));
    chk("cnt_q",      32'(cnt_q),      32'(m_cnt));
  endtask

  task automatic model_update(input bit r, input bit cv, input bit st, input bit sp);
    if (r) begin
      m_act = 0; m_per = 0; m_start = 0; m_end = 255; m_presc = 0; m_one = 0; m_cnt = 0;
    end else if (!m_act) begin
      if (cv) begin
        m_start = int'(cfg_start); m_end = int'(cfg_end);
        m_presc = int'(cfg_presc); m_one = cfg_oneshot;
      end
      if (st) begin
        m_act = 1; m_age = 0; m_per = 0;
      end
    end else if (sp) begin
      m_act = 0;
    end else begin
      if (e_tick) begin
        if (m_per < 65535) m_per++;
        if (m_one) m_act = 0;
      end
      m_age++;
    end
  endtask

  // One clock cycle: drive, check, advance model, cross the edge.
  task automatic step(input bit r, input bit cv, input bit st, input bit sp);
    reset = r; cfg_valid = cv; start = st; stop = sp;
    #1;
    e_tick = 0;
    if (!r) check_outputs();
    model_update(r, cv, st, sp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int s, input int e, input int p, input bit one);
    cfg_start = W'(s); cfg_end = W'(e); cfg_presc = PW'(p); cfg_oneshot = one;
  endtask

  initial begin
    bit found;
    reset = 1; cfg_valid = 0; start = 0; stop = 0;
    set_cfg(0, 0, 0, 0);
    @(posedge clk); #1;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);

    // Auto-reload 3..6, no prescale
    set_cfg(3, 6, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    repeat (10) step(0, 0, 0, 0);
    chk("periods_after_2_ticks", 32'(periods), 32'd2);
    repeat (6) step(0, 0, 0, 0);

    // cfg_valid while running is refused and ignored
    set_cfg(100, 200, 5, 1);
    repeat (3) step(0, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // Stop coincident with a terminal count
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_at_end()) begin
        step(0, 0, 0, 1);
        found = 1;
      end else begin
        step(0, 0, 0, 0);
      end
    end
    chk("stop_at_terminal_reached", 32'(found), 32'd1);
    repeat (3) step(0, 0, 0, 0);

    // cfg_valid and start in the same idle cycle: new start value used
    set_cfg(77, 79, 0, 0);
    step(0, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Wrapping sequence 250..2 with prescale 1
    set_cfg(250, 2, 1, 0);
    step(0, 1, 1, 0);
    repeat (40) step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // One-shot 0..2
    set_cfg(0, 2, 0, 1);
    step(0, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0);
    chk("oneshot_idle_ready", 32'(cfg_ready), 32'd1);

    // Reset mid-prescale, then a cold start on default configuration
    set_cfg(10, 20, 3, 0);
    step(0, 1, 1, 0);
    repeat (7) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (12) step(0, 0, 0, 0);
    step(0, 0, 0, 1);

    // Randomised sequences with sporadic stop/start/cfg noise
    for (int k = 0; k < 12; k++) begin
      cfg_start   = W'($urandom);
      cfg_end     = cfg_start + W'($urandom_range(0, 10));
      cfg_presc   = PW'($urandom_range(0, 3));
      cfg_oneshot = ($urandom_range(0, 3) == 0);
      step(0, 1, 1, 0);
      for (int j = 0; j < 60; j++) begin
        cfg_start   = W'($urandom);
        cfg_end     = cfg_start + W'($urandom_range(0, 6));
        cfg_presc   = PW'($urandom_range(0, 2));
        cfg_oneshot = ($urandom_range(0, 3) == 0);
        step(0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 39) == 0));
      end
      step(0, 0, 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_reload_ctrl.md
# counter_reload_ctrl

Sequencer upstream of the 8-bit parallel-load up-counter: drives its `load`, `data` and `enable` inputs and watches its `out` value. It turns a configured start value, end value and prescale ratio into periodic, or one-shot, count sequences. It emits a `tick` pulse each time a sequence completes. Configuration is accepted over a valid/ready handshake only while the block is idle.

## Interface
- `WIDTH`, 8: counter width; must match the downstream counter.
- `PRESC_W`, 8: prescaler width.
- `PERIOD_W`, 16: width of the completed-period counter.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration accepted this cycle when high together with `cfg_valid`.
- `cfg_start`  in  WIDTH  value loaded into the counter at the start of each sequence.
- `cfg_end`  in  WIDTH  terminal count.
- `cfg_presc`  in  PRESC_W  the counter advances once every `cfg_presc`+1 cycles.
- `cfg_oneshot`  in  1  1 = single sequence then idle; 0 = auto-reload.
- `start`  in  1  begin a sequence; honoured only in IDLE.
- `stop`  in  1  abort; honoured in LOAD and RUN.
- `cnt_q`  in  WIDTH  counter `out` fed back.
- `cnt_data`  out  WIDTH  to counter `data`.
- `cnt_load`  out  1  to counter `load`.
- `cnt_enable`  out  1  to counter `enable`.
- `tick`  out  1  one-cycle pulse; the terminal count is reached.
- `done`  out  1  one-cycle pulse; a one-shot sequence has finished.
- `busy`  out  1  high in LOAD and RUN.
- `periods`  out  PERIOD_W  completed sequences since `start`; saturates at all-ones.

## Operation
- States: IDLE, LOAD, RUN.
- Shadow registers hold `start_r`, `end_r`, `presc_r`, `oneshot_r`.
  - Captured on `cfg_valid && cfg_ready`.
  - `cfg_ready` = (state == IDLE).
- **IDLE:**
  - `start` moves to LOAD next cycle and clears `periods` to 0.
  - If `cfg_valid` and `start` are high in the same cycle, the new configuration is captured and is the one used.
- **LOAD:**
  - `cnt_load`=1 and `cnt_data`=`start_r` for exactly one cycle.
  - Next state is RUN, with the prescaler cleared to 0.
  - `stop` in LOAD returns to IDLE without asserting `cnt_load`.
- **RUN:**
  - The prescaler increments each cycle. Its terminal condition is `presc_cnt == presc_r`; at terminal it returns to 0.
  - At terminal with `cnt_q != end_r`: `cnt_enable`=1 for that cycle.
  - At terminal with `cnt_q == end_r`:
    - `tick`=1 and `periods` increments (saturating).
    - If `oneshot_r`: `done`=1 and the next state is IDLE.
    - Else: `cnt_load`=1 with `cnt_data`=`start_r` in the same cycle, and the state stays RUN.
  - `cnt_load` and `cnt_enable` are never high in the same cycle.
- **Priority:**
  - `stop` takes precedence over a terminal event: no `tick`, `done`, `cnt_load` or `cnt_enable` that cycle, and the next state is IDLE.
  - `start` and `cfg_valid` are ignored outside IDLE.
- **Wrap:**
  - `end_r` < `start_r` is legal; the counter wraps through all-ones to 0.
  - Only equality is compared.
- **Period:** ((`end_r` − `start_r`) mod 2^WIDTH + 1) × (`presc_r` + 1) cycles between ticks.
- `cnt_data` = `start_r` at all times. It is qualified only by `cnt_load`.
- **Reset mid-operation:** the next state is IDLE regardless of the current state. The counter itself is reset by the same `reset`.

## Timing
- Values after a clock edge with `reset`=1:
  - State = IDLE; `cnt_load`, `cnt_enable`, `tick`, `done`, `busy` = 0; `periods` = 0.
  - `start_r` = 0, `end_r` = all-ones, `presc_r` = 0, `oneshot_r` = 0.
  - `cfg_ready` = 1.
- Signal types:
  - `cnt_load`, `cnt_enable`, `tick`, `done`, `cfg_ready`, `busy` are combinational decodes of registered state, the prescaler and `cnt_q`.
  - `periods` is registered; it updates on the edge after `tick`.
- Counter behaviour: the counter registers `load`/`enable` on the next edge, so `cnt_q` reflects a load or increment one cycle later.
- Latency: `start` in cycle 0 → LOAD in cycle 1 → `cnt_q` = `start_r` and RUN in cycle 2.
- With `presc_r` = 0, `cnt_enable` is high every RUN cycle except terminal cycles.

## Structure
- Package `counter_ctrl_pkg`:
  - `ctrl_state_t` enum (IDLE, LOAD, RUN).
  - Default constants for `WIDTH`, `PRESC_W` and `PERIOD_W`.
  - Shared with the counter's bench.
- Sub-module `tick_prescaler`: `PRESC_W` counter with synchronous clear, compare value input and terminal-pulse output.
- The FSM, shadow registers and `periods` counter live in the top module.

## Test plan
- Reset, then config start=3, end=6, presc=0, oneshot=0; start → `cnt_q` sequence 3,4,5,6,3,…; `tick` every 4 cycles; `periods` = 2 after the second tick.
- start=250, end=2, presc=1 → counts 250..255,0,1,2 with `cnt_enable` every second cycle; tick period 18 cycles.
- oneshot=1, start=0, end=2, presc=0 → single `tick` coincident with `done`; `busy` drops the next cycle; `cfg_ready`=1.
- `stop` asserted in the same cycle as a terminal count → no `tick` and no `cnt_load`; IDLE next cycle; `cnt_q` held.
- `cfg_valid` during RUN → `cfg_ready`=0 and the running period is unchanged; `cfg_valid` and `start` in the same IDLE cycle → the new start value is loaded.
- `reset` in RUN, mid-prescale → all outputs at reset values after the edge; a subsequent `start` behaves as from cold.
